// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and buffers
// returned words with their PCs in an in-order FIFO for the decoder.
module instruction_fetch_unit #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } fetch_entry_t;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  fetch_entry_t  fifo_q [FIFO_DEPTH];
  fetch_entry_t  fifo_d [FIFO_DEPTH];

  logic          req_fire, rsp_fire, push, pop, credit_ok;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Dropped reads never land in the buffer, so only live reads consume credit.
  assign occupancy      = ({1'b0, inflight_q} - {1'b0, drop_q}) + {1'b0, count_q};
  assign credit_ok      = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instruction = fifo_q[rd_ptr_q].data;
  assign instr_pc    = fifo_q[rd_ptr_q].pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign push     = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;

    if (redirect_valid) begin
      // Everything still outstanding (minus a response landing now) is stale.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = inflight_q - CW'(rsp_fire);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 16'd1;
      if (rsp_fire && drop_q != '0) drop_d = drop_q - 1'b1;
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: rsp_pc_q, data: imem_rsp_data};
        rsp_pc_d         = rsp_pc_q + 16'd1;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= PC_RESET;
      rsp_pc_q   <= PC_RESET;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a fixed-latency memory whose
// word at address a is a ^ 16'hA5A5.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [15:0] instruction, instr_pc;

  int checks = 0;
  int errors = 0;
  int lat;
  int n_acc = 0;
  logic        pv [8];
  logic [15:0] pa [8];

  always #5 clk = ~clk;

  // Depth 3 covers the issue-to-pop round trip so fetch streams without bubbles.
  instruction_fetch_unit #(.PC_RESET(16'h0000), .FIFO_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  // Memory: a read accepted at an edge answers lat cycles later, in order.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
      imem_rsp_valid <= 1'b0;
      n_acc          <= 0;
    end else begin
      pv[0] <= imem_req_valid && imem_req_ready;
      pa[0] <= imem_req_addr;
      for (int i = 1; i < 8; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      imem_rsp_valid <= (lat == 1) ? (imem_req_valid && imem_req_ready) : pv[lat-2];
      imem_rsp_data  <= ((lat == 1) ? imem_req_addr : pa[lat-2]) ^ 16'hA5A5;
      n_acc          <= n_acc + ((imem_req_valid && imem_req_ready) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    redirect_valid = 1'b0;
    lat = l;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Collect n consecutive pcs from first (instr_ready held high), bounded in cycles.
  task automatic expect_seq(input string tag, input logic [15:0] first, input int n);
    logic [15:0] exp_pc;
    int got;
    exp_pc = first;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      if (instr_valid) begin
        chk({tag, "_pc"}, instr_pc, exp_pc);
        chk({tag, "_ins"}, instruction, exp_pc ^ 16'hA5A5);
        exp_pc = exp_pc + 16'd1;
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_cnt"}, got, n);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; lat = 1;

    // Reset state, then streaming at one instruction per cycle.
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_req_addr", imem_req_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_latency", instr_valid, 0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc", instr_pc, k);
      chk("t1_ins", instruction, 16'(k) ^ 16'hA5A5);
      @(negedge clk);
    end

    // Decoder stalled: only FIFO_DEPTH reads go out.
    instr_ready = 1'b0;
    do_reset(1);
    repeat (10) @(negedge clk);
    chk("t2_accepted", n_acc, 3);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_head_valid", instr_valid, 1);
    chk("t2_head_pc", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    expect_seq("t2", 16'h0000, 6);

    // Latency 3, redirect with two reads outstanding.
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    chk("t3_pre_addr", imem_req_addr, 16'h0002);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("t3_redir_no_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t3_flushed", instr_valid, 0);
    chk("t3_restart_addr", imem_req_addr, 16'h0040);
    expect_seq("t3", 16'h0040, 3);

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_valid", instr_valid, 1);
    chk("t4_pre_pc", instr_pc, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t4_empty", instr_valid, 0);
    chk("t4_addr", imem_req_addr, 16'h0100);
    chk("t4_req_valid", imem_req_valid, 1);
    expect_seq("t4", 16'h0100, 3);

    // PC wrap, then back-to-back redirects where the last one wins.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_seq("t5", 16'hFFFE, 4);
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    redirect_pc = 16'h0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_seq("t5b", 16'h0300, 2);

    // Reset with two entries buffered and one read in flight.
    instr_ready = 1'b0;
    do_reset(1);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", instr_valid, 1);
    chk("t6_pre_pc", instr_pc, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_req_addr", imem_req_addr, 16'h0000);
    rst = 1'b0; instr_ready = 1'b1;
    expect_seq("t6", 16'h0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
